fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares the single push port of a FiFo among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter multiplexes the winner's data onto the FiFo write data and drives push, honouring the FiFo full flag. A burst lock lets a winner push up to MAX_BURST consecutive words before priority rotates. The arbiter sits between producer blocks and the FiFo's io_din/io_push/io_full ports.

---
 rtl/fifo_push_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_push_arbiter
// Description : Round-robin arbiter sharing one FiFo push port between
//               NUM_REQ valid/ready producers. Zero-latency data path with
//               a burst lock: a winner may push up to MAX_BURST consecutive
//               words before priority rotates past it.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 2,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            io_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] io_req_data,
  output logic [NUM_REQ-1:0]            io_req_ready,
  input  logic                          io_fifo_full,
  output logic                          io_fifo_push,
  output logic [DATA_WIDTH-1:0]         io_fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    io_grant_id,
  output logic                          io_busy
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_IDW = $clog2(NUM_REQ);
  localparam int c_CW  = $clog2(MAX_BURST + 1);

  // Highest legal requester index; pointer increments wrap here, which keeps
  // non-power-of-two NUM_REQ values correct.
  localparam logic [c_IDW-1:0] c_LAST_IDX    = c_IDW'(NUM_REQ - 1);
  // Requester count one bit wider than an index, used by the modulo scan.
  localparam logic [c_IDW:0]   c_NUM_REQ_EXT = (c_IDW + 1)'(NUM_REQ);
  localparam logic [c_CW-1:0]  c_BURST_MAX   = c_CW'(MAX_BURST);
  localparam logic [c_CW-1:0]  c_BURST_ONE   = c_CW'(1);
  localparam logic [NUM_REQ-1:0] c_ONEHOT_LSB = NUM_REQ'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_IDW-1:0] r_ptr;        // first index scanned when no lock is held
  logic [c_IDW-1:0] r_owner;      // most recent winner
  logic [c_CW-1:0]  r_burst_cnt;  // words pushed by owner in current burst
  logic             r_locked;     // owner holds the burst lock

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic               w_owner_valid;
  logic [c_IDW-1:0]   w_start;
  logic [c_IDW:0]     w_scan_sum;
  logic [c_IDW-1:0]   w_scan_idx;
  logic               w_scan_found;
  logic [c_IDW-1:0]   w_cand;
  logic               w_none;
  logic               w_fire;
  logic               w_same_owner;
  logic [c_CW-1:0]    w_next_cnt;
  logic               w_burst_done;
  logic [NUM_REQ-1:0] w_onehot;
  logic [DATA_WIDTH-1:0] w_din;

  // Increment an index modulo NUM_REQ.
  function automatic logic [c_IDW-1:0] f_wrap_inc(input logic [c_IDW-1:0] idx);
    return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign w_owner_valid = io_req_valid[r_owner];
  assign w_none        = ~|io_req_valid;
  // While locked the owner has priority; if it has dropped out, scanning
  // starts just after it so it does not win again ahead of the others.
  assign w_start       = r_locked ? f_wrap_inc(r_owner) : r_ptr;
  assign w_fire        = !w_none && !io_fifo_full;

  // Rotating priority scan: first valid requester at or after w_start.
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    w_scan_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, w_start} + (c_IDW + 1)'(k);
      if (w_scan_sum >= c_NUM_REQ_EXT) begin
        w_scan_sum = w_scan_sum - c_NUM_REQ_EXT;
      end
      if (!w_scan_found && io_req_valid[w_scan_sum[c_IDW-1:0]]) begin
        w_scan_found = 1'b1;
        w_scan_idx   = w_scan_sum[c_IDW-1:0];
      end
    end
  end

  // Candidate choice: a locked owner that is still valid keeps the port.
  always_comb begin
    w_cand = '0;
    if (r_locked && w_owner_valid) begin
      w_cand = r_owner;
    end else if (w_scan_found) begin
      w_cand = w_scan_idx;
    end
  end

  // Write-data multiplexer selecting the candidate's word.
  always_comb begin
    w_din = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_cand == c_IDW'(k)) begin
        w_din = io_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_onehot = c_ONEHOT_LSB << w_cand;

  // Burst accounting: a push continues the burst only if the lock is held
  // by the same requester; any other winner starts a fresh burst of one.
  assign w_same_owner = r_locked && (w_cand == r_owner);
  assign w_next_cnt   = w_same_owner ? (r_burst_cnt + 1'b1) : c_BURST_ONE;
  assign w_burst_done = (w_next_cnt == c_BURST_MAX);

  // Output drive; everything is held quiet while reset is asserted.
  always_comb begin
    io_fifo_push = 1'b0;
    io_req_ready = '0;
    io_grant_id  = '0;
    io_busy      = 1'b0;
    io_fifo_din  = w_din;
    if (!reset) begin
      io_fifo_push = w_fire;
      io_req_ready = w_fire ? w_onehot : '0;
      io_grant_id  = w_cand;
      io_busy      = r_locked;
    end
  end

  // Arbitration state update: burst progress on a push, lock release when
  // the owner walks away, and full hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_locked    <= 1'b0;
    end else if (w_fire) begin
      r_owner <= w_cand;
      if (w_burst_done) begin
        r_locked    <= 1'b0;
        r_burst_cnt <= '0;
        r_ptr       <= f_wrap_inc(w_cand);
      end else begin
        r_locked    <= 1'b1;
        r_burst_cnt <= w_next_cnt;
      end
    end else if (r_locked && !w_owner_valid) begin
      r_locked    <= 1'b0;
      r_burst_cnt <= '0;
      r_ptr       <= f_wrap_inc(r_owner);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_push_arbiter
// Description : Self-checking bench for fifo_push_arbiter. Two instances
//               (MAX_BURST=2 and MAX_BURST=1) share stimulus and are compared
//               each cycle against a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         r_rst;
  logic [N-1:0] r_valid;
  logic [7:0]   r_data;
  logic         r_full;

  logic         w_push_a, w_busy_a, w_push_b, w_busy_b;
  logic [N-1:0] w_ready_a, w_ready_b;
  logic [1:0]   w_din_a, w_gid_a, w_din_b, w_gid_b;

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(2)) u_dut_a (
    .clk(clk), .reset(r_rst), .io_req_valid(r_valid), .io_req_data(r_data),
    .io_req_ready(w_ready_a), .io_fifo_full(r_full), .io_fifo_push(w_push_a),
    .io_fifo_din(w_din_a), .io_grant_id(w_gid_a), .io_busy(w_busy_a)
  );

  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .reset(r_rst), .io_req_valid(r_valid), .io_req_data(r_data),
    .io_req_ready(w_ready_b), .io_fifo_full(r_full), .io_fifo_push(w_push_b),
    .io_fifo_din(w_din_b), .io_grant_id(w_gid_b), .io_busy(w_busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one slot per instance.
  int m_ptr[2];
  int m_owner[2];
  int m_cnt[2];
  bit m_locked[2];
  int m_maxb[2] = '{2, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, compare settled
  // outputs against the model, then advance the model for the rising edge.
  task automatic step(input logic [N-1:0] v, input logic [7:0] d,
                      input logic f, input logic r);
    int cand, start, idx, n;
    bit none, fire, found;
    logic push, busy;
    logic [N-1:0] rdy;
    logic [1:0] din, gid;
    string sfx;
    @(negedge clk);
    r_rst = r; r_valid = v; r_data = d; r_full = f;
    #1;
    for (int u = 0; u < 2; u++) begin
      sfx  = (u == 0) ? "mb2" : "mb1";
      push = (u == 0) ? w_push_a  : w_push_b;
      busy = (u == 0) ? w_busy_a  : w_busy_b;
      rdy  = (u == 0) ? w_ready_a : w_ready_b;
      din  = (u == 0) ? w_din_a   : w_din_b;
      gid  = (u == 0) ? w_gid_a   : w_gid_b;

      none = (v == '0);
      cand = 0;
      if (m_locked[u] && v[m_owner[u]]) begin
        cand = m_owner[u];
      end else begin
        start = m_locked[u] ? (m_owner[u] + 1) % N : m_ptr[u];
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (start + k) % N;
          if (!found && v[idx]) begin
            found = 1'b1;
            cand  = idx;
          end
        end
      end
      fire = !none && !f;

      if (r) begin
        check({"rst_push_", sfx}, 32'(push), 32'(0));
        check({"rst_ready_", sfx}, 32'(rdy), 32'(0));
        check({"rst_busy_", sfx}, 32'(busy), 32'(0));
        check({"rst_gid_", sfx}, 32'(gid), 32'(0));
        m_ptr[u] = 0; m_owner[u] = 0; m_cnt[u] = 0; m_locked[u] = 1'b0;
      end else begin
        check({"push_", sfx}, 32'(push), 32'(fire));
        check({"ready_", sfx}, 32'(rdy), fire ? (32'(1) << cand) : 32'(0));
        check({"gid_", sfx}, 32'(gid), 32'(cand));
        check({"busy_", sfx}, 32'(busy), 32'(m_locked[u]));
        if (fire) check({"din_", sfx}, 32'(din), 32'((d >> (cand * DW)) & 8'h3));

        if (fire) begin
          n = (m_locked[u] && cand == m_owner[u]) ? m_cnt[u] + 1 : 1;
          m_owner[u] = cand;
          if (n == m_maxb[u]) begin
            m_locked[u] = 1'b0; m_cnt[u] = 0; m_ptr[u] = (cand + 1) % N;
          end else begin
            m_locked[u] = 1'b1; m_cnt[u] = n;
          end
        end else if (m_locked[u] && !v[m_owner[u]]) begin
          m_locked[u] = 1'b0; m_cnt[u] = 0; m_ptr[u] = (m_owner[u] + 1) % N;
        end
      end
    end
  endtask

  int seq_a[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int seq_b[9]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int busy_a[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    r_rst = 1'b1; r_valid = '0; r_data = '0; r_full = 1'b0;

    // Reset with everyone requesting, then free-running rotation.
    step(4'b1111, 8'hE4, 1'b0, 1'b1);
    step(4'b1111, 8'hE4, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(4'b1111, 8'hE4, 1'b0, 1'b0);
      check("seq_gid_mb2", 32'(w_gid_a), 32'(seq_a[i]));
      check("seq_gid_mb1", 32'(w_gid_b), 32'(seq_b[i]));
      check("seq_busy_mb2", 32'(w_busy_a), 32'(busy_a[i]));
      check("seq_busy_mb1", 32'(w_busy_b), 32'(0));
      check("seq_push_mb2", 32'(w_push_a), 32'(1));
    end

    // Single requester repeatedly re-acquires after each burst.
    step(4'b0000, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, 8'h20, 1'b0, 1'b0);
      check("solo_din", 32'(w_din_a), 32'(2));
      check("solo_gid", 32'(w_gid_a), 32'(2));
      check("solo_busy", 32'(w_busy_a), 32'(i % 2));
    end

    // Lock survives backpressure, then priority rotates past the owner.
    step(4'b0000, 8'h00, 1'b0, 1'b1);
    step(4'b0010, 8'h1B, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 8'h1B, 1'b1, 1'b0);
      check("bp_push", 32'(w_push_a), 32'(0));
      check("bp_busy", 32'(w_busy_a), 32'(1));
    end
    step(4'b0011, 8'h1B, 1'b0, 1'b0);
    check("bp_resume_gid", 32'(w_gid_a), 32'(1));
    step(4'b0011, 8'h1B, 1'b0, 1'b0);
    check("bp_wrap_gid", 32'(w_gid_a), 32'(0));

    // Owner abandons its burst; another requester takes over the same cycle.
    step(4'b0000, 8'h00, 1'b0, 1'b1);
    step(4'b0001, 8'h93, 1'b0, 1'b0);
    step(4'b1000, 8'h93, 1'b0, 1'b0);
    check("abandon_gid", 32'(w_gid_a), 32'(3));
    check("abandon_ready", 32'(w_ready_a), 32'(4'b1000));
    step(4'b1000, 8'h93, 1'b0, 1'b0);
    check("abandon_busy", 32'(w_busy_a), 32'(1));

    // Randomised traffic with occasional backpressure and resets.
    for (int i = 0; i < 500; i++) begin
      step(4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
